// File: rtl/gray_sobel_bist_ctrl.sv
// BIST sequencer: clears the SA, seeds the LFSR, runs one frame and checks the signature.
// Optional macro BIST_ERR_CAPTURE_EN keeps the failing signature on err_sig_o.
module gray_sobel_bist_ctrl #(
  parameter int MAX_PIXEL_BITS = 24,
  parameter int FRAME_PIXELS   = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [MAX_PIXEL_BITS-1:0] seed_i,
  input  logic [MAX_PIXEL_BITS-1:0] golden_i,
  output logic                      lfsr_cfg_o,
  output logic                      lfsr_cfg_rdy_o,
  output logic [MAX_PIXEL_BITS-1:0] lfsr_cfg_data_o,
  input  logic                      lfsr_cfg_done_i,
  output logic                      lfsr_en_o,
  input  logic                      px_rdy_i,
  output logic                      sa_en_o,
  output logic                      sa_clear_o,
  input  logic [MAX_PIXEL_BITS-1:0] sa_signature_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [MAX_PIXEL_BITS-1:0] err_sig_o
);

  localparam int PIX_W = $clog2(FRAME_PIXELS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED, S_WAIT_SEED, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t                    r_state, w_next;
  logic                      r_start_q;
  logic [PIX_W-1:0]          r_pix_cnt;
  logic [WD_W-1:0]           r_wd_cnt;
  logic [MAX_PIXEL_BITS-1:0] r_seed, r_golden;
  logic                      r_done, r_pass, r_timeout;
  logic                      w_start_edge, w_launch, w_timeout, w_wd_on;

  assign w_start_edge = start_i & ~r_start_q;
  assign w_wd_on      = (r_state == S_WAIT_SEED) || (r_state == S_RUN);

  // Progress (cfg_done or a pixel) takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_timeout = 1'b0;
    if (abort_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_start_edge) begin
          w_next   = S_CLEAR;
          w_launch = 1'b1;
        end
        S_CLEAR: w_next = S_SEED;
        S_SEED:  w_next = S_WAIT_SEED;
        S_WAIT_SEED: begin
          if (lfsr_cfg_done_i) w_next = S_RUN;
          else if (r_wd_cnt == WD_LAST) begin
            w_next    = S_DONE;
            w_timeout = 1'b1;
          end
        end
        S_RUN: begin
          if (px_rdy_i) begin
            if (r_pix_cnt == PIX_LAST) w_next = S_DRAIN;
          end else if (r_wd_cnt == WD_LAST) begin
            w_next    = S_DONE;
            w_timeout = 1'b1;
          end
        end
        S_DRAIN: w_next = S_CHECK;
        S_CHECK: w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // start_q resets high so a start level held through reset is not seen as an edge.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_pix_cnt <= '0;
      r_wd_cnt  <= '0;
      r_seed    <= '0;
      r_golden  <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start_i;
      r_done    <= (w_next == S_DONE) && (r_state != S_DONE);

      if (abort_i || w_launch)              r_pix_cnt <= '0;
      else if (r_state == S_RUN && px_rdy_i) r_pix_cnt <= r_pix_cnt + 1'b1;

      if ((w_next != r_state) || !w_wd_on || (r_state == S_RUN && px_rdy_i))
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_launch) begin
        r_seed   <= seed_i;
        r_golden <= golden_i;
      end

      if (abort_i || w_launch) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b1;
      end else if (r_state == S_CHECK) begin
        r_pass    <= (sa_signature_i == r_golden);
      end
    end
  end

`ifdef BIST_ERR_CAPTURE_EN
  logic [MAX_PIXEL_BITS-1:0] r_err_sig;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                                     r_err_sig <= '0;
    else if (abort_i || w_launch)                      r_err_sig <= '0;
    else if (r_state == S_CHECK && sa_signature_i != r_golden) r_err_sig <= sa_signature_i;
  end

  assign err_sig_o = r_err_sig;
`else
  assign err_sig_o = '0;
`endif

  assign lfsr_cfg_o      = (r_state == S_SEED) || (r_state == S_WAIT_SEED);
  assign lfsr_cfg_rdy_o  = (r_state == S_SEED);
  assign lfsr_cfg_data_o = r_seed;
  assign lfsr_en_o       = (r_state == S_RUN);
  assign sa_en_o         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign sa_clear_o      = (r_state == S_CLEAR);
  assign busy_o          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign timeout_o       = r_timeout;

endmodule
